// File: rtl/mqoi_delta_stream_if.sv
// Purpose: streaming bundle for the MQOI frame-delta engine.
//   Input side : in_valid/in_ready handshake carrying in_old (previous frame
//                pixels) and in_cur (current pixels or diff pixels).
//   Output side: out_valid/out_ready handshake carrying out_pix and out_last.
// Modports:
//   master - the environment (drives inputs, consumes outputs)
//   slave  - the engine (accepts inputs, produces outputs)
interface mqoi_delta_stream_if #(
  parameter int CW    = 8,
  parameter int LANES = 1
);
  localparam int PW = LANES * 4 * CW;

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_old;
  logic [PW-1:0] in_cur;

  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_pix;
  logic          out_last;

  modport master (
    output in_valid, in_old, in_cur, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  in_valid, in_old, in_cur, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );
endinterface

// File: rtl/mqoi_delta_stream.sv
// Purpose: two-stage pipelined MQOI frame-delta engine. ENCODE turns
//   (old, cur) into a diff pixel, COMPOSE turns (old, diff) back into a new
//   pixel. LANES pixels per beat, channels {a,b,g,r} MSB..LSB per pixel.
//   Tracks frame boundaries (FRAME_BEATS beats per frame) and reports the
//   number of changed pixels of the most recently completed frame.
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   i_mode          0=ENCODE, 1=COMPOSE; sampled on the first beat of a frame
//   bus             stream bundle (slave side): in_* / out_* handshakes
//   o_frame_done    one-cycle pulse after the last beat of a frame leaves
//   o_frame_changed changed-pixel count of the last completed frame
module mqoi_delta_stream #(
  parameter int CW          = 8,
  parameter int LANES       = 1,
  parameter int FRAME_BEATS = 1024,
  localparam int CNT_W      = $clog2(FRAME_BEATS * LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_mode,
  mqoi_delta_stream_if.slave   bus,
  output logic                 o_frame_done,
  output logic [CNT_W-1:0]     o_frame_changed
);

  localparam int PXW  = 4 * CW;
  localparam int RGBW = 3 * CW;
  localparam int PW   = LANES * PXW;
  localparam int BW   = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] AMAX     = {CW{1'b1}};

  // frame tracking
  logic [BW-1:0]    r_beat;
  logic             r_mode_q;

  // stage 1: registered inputs
  logic             r_s1_valid;
  logic [PW-1:0]    r_s1_old;
  logic [PW-1:0]    r_s1_cur;
  logic             r_s1_mode;
  logic             r_s1_last;

  // stage 2: result
  logic             r_s2_valid;
  logic [PW-1:0]    r_s2_pix;
  logic             r_s2_last;
  logic [CNT_W-1:0] r_s2_cnt;

  // statistics
  logic [CNT_W-1:0] r_running;
  logic [CNT_W-1:0] r_frame_changed;
  logic             r_frame_done;

  logic             w_s2_drain;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_beat_last;
  logic             w_mode_eff;
  logic [PW-1:0]    w_res;
  logic [LANES-1:0] w_chg;
  logic [CNT_W-1:0] w_cnt;

  assign w_s2_drain = r_s2_valid & bus.out_ready;
  assign w_s2_free  = ~r_s2_valid | w_s2_drain;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  // Held low during reset; otherwise ready whenever S1 is empty or moving,
  // so a full-rate stream never sees a bubble.
  assign w_in_ready = rst_n & (~r_s1_valid | w_s1_adv);
  assign w_acc      = bus.in_valid & w_in_ready;

  assign w_beat_last = (r_beat == LAST_IDX);
  // First beat of a frame uses the live mode pin; the rest of the frame
  // follows the latched copy so mid-frame toggles have no effect.
  assign w_mode_eff  = (r_beat == '0) ? i_mode : r_mode_q;

  // Per-lane delta rule, evaluated on S1 contents.
  always_comb begin
    w_res = '0;
    w_chg = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!r_s1_mode) begin
        // ENCODE: alpha of cur is ignored; an all-zero pixel means "keep".
        if (r_s1_old[k*PXW +: RGBW] == r_s1_cur[k*PXW +: RGBW]) begin
          w_chg[k]              = 1'b0;
          w_res[k*PXW +: PXW]   = '0;
        end else begin
          w_chg[k]              = 1'b1;
          w_res[k*PXW +: PXW]   = {AMAX, r_s1_cur[k*PXW +: RGBW]};
        end
      end else begin
        // COMPOSE: any nonzero diff alpha is treated as a full replacement.
        if (r_s1_cur[k*PXW + RGBW +: CW] == '0) begin
          w_chg[k]              = 1'b0;
          w_res[k*PXW +: PXW]   = {AMAX, r_s1_old[k*PXW +: RGBW]};
        end else begin
          w_chg[k]              = 1'b1;
          w_res[k*PXW +: PXW]   = {AMAX, r_s1_cur[k*PXW +: RGBW]};
        end
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      w_cnt = w_cnt + CNT_W'(w_chg[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat          <= '0;
      r_mode_q        <= 1'b0;
      r_s1_valid      <= 1'b0;
      r_s1_old        <= '0;
      r_s1_cur        <= '0;
      r_s1_mode       <= 1'b0;
      r_s1_last       <= 1'b0;
      r_s2_valid      <= 1'b0;
      r_s2_pix        <= '0;
      r_s2_last       <= 1'b0;
      r_s2_cnt        <= '0;
      r_running       <= '0;
      r_frame_changed <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
        if (r_beat == '0) begin
          r_mode_q <= i_mode;
        end
      end

      if (w_acc) begin
        r_s1_valid <= 1'b1;
        r_s1_old   <= bus.in_old;
        r_s1_cur   <= bus.in_cur;
        r_s1_mode  <= w_mode_eff;
        r_s1_last  <= w_beat_last;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_pix   <= w_res;
        r_s2_last  <= r_s1_last;
        r_s2_cnt   <= w_cnt;
      end else if (w_s2_drain) begin
        r_s2_valid <= 1'b0;
      end

      // Counting happens at the output handshake, so a frame boundary
      // draining while the next frame enters S1 never mixes counts.
      r_frame_done <= 1'b0;
      if (w_s2_drain) begin
        if (r_s2_last) begin
          r_frame_changed <= r_running + r_s2_cnt;
          r_running       <= '0;
          r_frame_done    <= 1'b1;
        end else begin
          r_running <= r_running + r_s2_cnt;
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_s2_valid;
  assign bus.out_pix      = r_s2_pix;
  assign bus.out_last     = r_s2_last;
  assign o_frame_done     = r_frame_done;
  assign o_frame_changed  = r_frame_changed;

endmodule
